// File: rtl/riscv_lsu.sv
// Load/store unit: one request/acknowledge transaction per load or store,
// with byte-lane steering, load extension and misalign/illegal/timeout status.
module riscv_lsu #(
    parameter int unsigned MAX_WAIT = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        is_store,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        o_busy,
    output logic        o_done,
    output logic [1:0]  o_status,
    output logic [31:0] o_rdata,
    output logic        o_mem_req,
    output logic        o_mem_we,
    output logic [31:0] o_mem_addr,
    output logic [31:0] o_mem_wdata,
    output logic [3:0]  o_mem_be,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);

    localparam int unsigned DW  = 32;
    localparam int unsigned BEW = 4;
    localparam int unsigned CW  = 8;

    localparam logic [1:0]    ST_OK    = 2'b00;
    localparam logic [1:0]    ST_MIS   = 2'b01;
    localparam logic [1:0]    ST_ILL   = 2'b10;
    localparam logic [1:0]    ST_TMO   = 2'b11;
    localparam logic [CW-1:0] LAST_CNT = CW'(MAX_WAIT - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_REQ  = 2'b01,
        S_DONE = 2'b10
    } state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            is_store_q, is_store_d;
    logic [2:0]      funct3_q, funct3_d;
    logic [1:0]      off_q, off_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic [1:0]      status_q, status_d;
    logic [DW-1:0]   rdata_q, rdata_d;
    logic            req_q, req_d;
    logic            we_q, we_d;
    logic [DW-1:0]   maddr_q, maddr_d;
    logic [DW-1:0]   mwdata_q, mwdata_d;
    logic [BEW-1:0]  be_q, be_d;

    logic            illegal_c;
    logic            misaligned_c;
    logic [BEW-1:0]  be_c;
    logic [DW-1:0]   lane_wdata_c;
    logic [DW-1:0]   shifted_c;
    logic [DW-1:0]   load_ext_c;

    // Decode of the incoming instruction; funct3[1:0] gives the access size.
    always_comb begin
        illegal_c    = 1'b0;
        misaligned_c = 1'b0;
        be_c         = 4'b1111;
        lane_wdata_c = wdata;
        if (is_store) begin
            illegal_c = funct3[2] || (funct3[1:0] == 2'b11);
        end else begin
            illegal_c = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
        end
        case (funct3[1:0])
            2'b00: begin
                be_c         = BEW'(4'b0001 << addr[1:0]);
                lane_wdata_c = {4{wdata[7:0]}};
            end
            2'b01: begin
                misaligned_c = addr[0];
                be_c         = BEW'(4'b0011 << addr[1:0]);
                lane_wdata_c = {2{wdata[15:0]}};
            end
            2'b10:   misaligned_c = (addr[1:0] != 2'b00);
            default: misaligned_c = 1'b0;
        endcase
    end

    // Load data steering and extension from the latched access.
    always_comb begin
        shifted_c = mem_rdata >> {off_q, 3'b000};
        case (funct3_q)
            3'b000:  load_ext_c = {{24{shifted_c[7]}}, shifted_c[7:0]};
            3'b001:  load_ext_c = {{16{shifted_c[15]}}, shifted_c[15:0]};
            3'b100:  load_ext_c = {24'd0, shifted_c[7:0]};
            3'b101:  load_ext_c = {16'd0, shifted_c[15:0]};
            default: load_ext_c = shifted_c;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        is_store_d = is_store_q;
        funct3_d   = funct3_q;
        off_d      = off_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        status_d   = status_q;
        rdata_d    = rdata_q;
        req_d      = req_q;
        we_d       = we_q;
        maddr_d    = maddr_q;
        mwdata_d   = mwdata_q;
        be_d       = be_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    is_store_d = is_store;
                    funct3_d   = funct3;
                    off_d      = addr[1:0];
                    if (illegal_c || misaligned_c) begin
                        state_d  = S_DONE;
                        done_d   = 1'b1;
                        status_d = illegal_c ? ST_ILL : ST_MIS;
                        rdata_d  = '0;
                    end else begin
                        state_d  = S_REQ;
                        cnt_d    = '0;
                        busy_d   = 1'b1;
                        req_d    = 1'b1;
                        we_d     = is_store;
                        maddr_d  = {addr[31:2], 2'b00};
                        mwdata_d = lane_wdata_c;
                        be_d     = be_c;
                    end
                end
            end
            S_REQ: begin
                if (mem_ack || (cnt_q == LAST_CNT)) begin
                    state_d  = S_DONE;
                    done_d   = 1'b1;
                    busy_d   = 1'b0;
                    req_d    = 1'b0;
                    we_d     = 1'b0;
                    be_d     = '0;
                    if (mem_ack) begin
                        status_d = ST_OK;
                        if (!is_store_q) begin
                            rdata_d = load_ext_c;
                        end
                    end else begin
                        status_d = ST_TMO;
                        rdata_d  = '0;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            is_store_q <= 1'b0;
            funct3_q   <= '0;
            off_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            status_q   <= '0;
            rdata_q    <= '0;
            req_q      <= 1'b0;
            we_q       <= 1'b0;
            maddr_q    <= '0;
            mwdata_q   <= '0;
            be_q       <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            is_store_q <= is_store_d;
            funct3_q   <= funct3_d;
            off_q      <= off_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            status_q   <= status_d;
            rdata_q    <= rdata_d;
            req_q      <= req_d;
            we_q       <= we_d;
            maddr_q    <= maddr_d;
            mwdata_q   <= mwdata_d;
            be_q       <= be_d;
        end
    end

    assign o_busy      = busy_q;
    assign o_done      = done_q;
    assign o_status    = status_q;
    assign o_rdata     = rdata_q;
    assign o_mem_req   = req_q;
    assign o_mem_we    = we_q;
    assign o_mem_addr  = maddr_q;
    assign o_mem_wdata = mwdata_q;
    assign o_mem_be    = be_q;

endmodule

// File: tb/tb_riscv_lsu.sv
// Directed bench for riscv_lsu (MAX_WAIT=4): loads, stores, error paths,
// timeout, reset abort and start held through DONE.
module tb_riscv_lsu;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        is_store;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        o_busy;
    logic        o_done;
    logic [1:0]  o_status;
    logic [31:0] o_rdata;
    logic        o_mem_req;
    logic        o_mem_we;
    logic [31:0] o_mem_addr;
    logic [31:0] o_mem_wdata;
    logic [3:0]  o_mem_be;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    int errors = 0;
    int checks = 0;
    int done_cnt = 0;
    int done_before;

    riscv_lsu #(.MAX_WAIT(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .is_store   (is_store),
        .funct3     (funct3),
        .addr       (addr),
        .wdata      (wdata),
        .o_busy     (o_busy),
        .o_done     (o_done),
        .o_status   (o_status),
        .o_rdata    (o_rdata),
        .o_mem_req  (o_mem_req),
        .o_mem_we   (o_mem_we),
        .o_mem_addr (o_mem_addr),
        .o_mem_wdata(o_mem_wdata),
        .o_mem_be   (o_mem_be),
        .mem_ack    (mem_ack),
        .mem_rdata  (mem_rdata)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (o_done === 1'b1) done_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Presents an instruction for one cycle; returns in cycle 1.
    task automatic issue(input logic st, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd);
        start    = 1'b1;
        is_store = st;
        funct3   = f3;
        addr     = a;
        wdata    = wd;
        step();
        start = 1'b0;
    endtask

    initial begin
        rst_n     = 1'b0;
        start     = 1'b0;
        is_store  = 1'b0;
        funct3    = 3'b000;
        addr      = '0;
        wdata     = '0;
        mem_ack   = 1'b0;
        mem_rdata = '0;
        step();
        step();
        chk("rst_busy",  32'(o_busy),    32'd0);
        chk("rst_done",  32'(o_done),    32'd0);
        chk("rst_req",   32'(o_mem_req), 32'd0);
        chk("rst_be",    32'(o_mem_be),  32'd0);
        chk("rst_rdata", o_rdata,        32'd0);
        rst_n = 1'b1;
        step();

        // LW 0x100, ack in cycle 1
        issue(1'b0, 3'b010, 32'h100, 32'h0);
        chk("lw_req1",  32'(o_mem_req),  32'd1);
        chk("lw_busy1", 32'(o_busy),     32'd1);
        chk("lw_addr",  o_mem_addr,      32'h100);
        chk("lw_be",    32'(o_mem_be),   32'hF);
        chk("lw_we",    32'(o_mem_we),   32'd0);
        chk("lw_done1", 32'(o_done),     32'd0);
        mem_ack   = 1'b1;
        mem_rdata = 32'hDEADBEEF;
        step();
        mem_ack = 1'b0;
        chk("lw_done2",  32'(o_done),    32'd1);
        chk("lw_status", 32'(o_status),  32'd0);
        chk("lw_rdata",  o_rdata,        32'hDEADBEEF);
        chk("lw_req2",   32'(o_mem_req), 32'd0);
        step();
        chk("lw_done3",  32'(o_done),    32'd0);
        chk("lw_busy3",  32'(o_busy),    32'd0);

        // LB / LBU from 0x103
        issue(1'b0, 3'b000, 32'h103, 32'h0);
        chk("lb_be", 32'(o_mem_be), 32'h8);
        chk("lb_addr", o_mem_addr, 32'h100);
        mem_ack   = 1'b1;
        mem_rdata = 32'h80FF7F01;
        step();
        mem_ack = 1'b0;
        chk("lb_rdata", o_rdata, 32'hFFFFFF80);
        step();
        issue(1'b0, 3'b100, 32'h103, 32'h0);
        mem_ack = 1'b1;
        step();
        mem_ack = 1'b0;
        chk("lbu_rdata", o_rdata, 32'h00000080);
        step();

        // SH to 0x202
        issue(1'b1, 3'b001, 32'h202, 32'h1234ABCD);
        chk("sh_addr",  o_mem_addr,     32'h200);
        chk("sh_we",    32'(o_mem_we),  32'd1);
        chk("sh_be",    32'(o_mem_be),  32'hC);
        chk("sh_wdata", o_mem_wdata,    32'hABCDABCD);
        mem_ack   = 1'b1;
        mem_rdata = 32'h55555555;
        step();
        mem_ack = 1'b0;
        chk("sh_done",   32'(o_done),   32'd1);
        chk("sh_status", 32'(o_status), 32'd0);
        chk("sh_rdata",  o_rdata,       32'h00000080);
        step();

        // Misaligned LW and illegal store encoding
        issue(1'b0, 3'b010, 32'h101, 32'h0);
        chk("mis_done",   32'(o_done),    32'd1);
        chk("mis_status", 32'(o_status),  32'd1);
        chk("mis_req",    32'(o_mem_req), 32'd0);
        chk("mis_rdata",  o_rdata,        32'd0);
        step();
        chk("mis_req2",   32'(o_mem_req), 32'd0);
        issue(1'b1, 3'b011, 32'h100, 32'h0);
        chk("ill_done",   32'(o_done),    32'd1);
        chk("ill_status", 32'(o_status),  32'd2);
        chk("ill_req",    32'(o_mem_req), 32'd0);
        step();

        // Ack arriving in the last allowed cycle (4) wins over timeout
        issue(1'b0, 3'b010, 32'h104, 32'h0);
        step();
        step();
        step();
        chk("late_req4", 32'(o_mem_req), 32'd1);
        mem_ack   = 1'b1;
        mem_rdata = 32'hCAFEF00D;
        step();
        mem_ack = 1'b0;
        chk("late_done",   32'(o_done),   32'd1);
        chk("late_status", 32'(o_status), 32'd0);
        chk("late_rdata",  o_rdata,       32'hCAFEF00D);
        step();

        // Timeout: req in cycles 1..4, done with status 11 in cycle 5
        issue(1'b0, 3'b010, 32'h108, 32'h0);
        chk("tmo_req1", 32'(o_mem_req), 32'd1);
        for (int c = 2; c <= 4; c++) begin
            step();
            chk($sformatf("tmo_req%0d", c),  32'(o_mem_req), 32'd1);
            chk($sformatf("tmo_done%0d", c), 32'(o_done),    32'd0);
        end
        step();
        chk("tmo_done5",   32'(o_done),    32'd1);
        chk("tmo_status",  32'(o_status),  32'd3);
        chk("tmo_rdata",   o_rdata,        32'd0);
        chk("tmo_req5",    32'(o_mem_req), 32'd0);
        step();

        // Reset in cycle 2 of a wait aborts the access
        done_before = done_cnt;
        issue(1'b0, 3'b010, 32'h10C, 32'h0);
        step();
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_req",  32'(o_mem_req), 32'd0);
        chk("arst_busy", 32'(o_busy),    32'd0);
        step();
        rst_n = 1'b1;
        step();
        step();
        step();
        chk("arst_nodone", 32'(done_cnt - done_before), 32'd0);

        // start held high through DONE yields exactly one access
        done_before = done_cnt;
        start    = 1'b1;
        is_store = 1'b0;
        funct3   = 3'b010;
        addr     = 32'h110;
        step();
        mem_ack   = 1'b1;
        mem_rdata = 32'h11223344;
        step();
        mem_ack = 1'b0;
        chk("hold_done", 32'(o_done), 32'd1);
        step();
        start = 1'b0;
        chk("hold_idle_req", 32'(o_mem_req), 32'd0);
        chk("hold_idle_busy", 32'(o_busy),   32'd0);
        step();
        step();
        chk("hold_req_after", 32'(o_mem_req), 32'd0);
        chk("hold_count", 32'(done_cnt - done_before), 32'd1);
        chk("hold_rdata", o_rdata, 32'h11223344);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/riscv_lsu.md
# riscv_lsu

Load/store unit between the ALU result and data memory. It takes the ALU sum as the effective address, runs one request/acknowledge transaction on the data-memory bus, and returns load data aligned and sign/zero-extended for writeback. While a transaction is in flight it stalls the core through `o_busy`. It detects misaligned addresses, illegal `funct3` encodings and bus timeouts, and reports them as status codes.

## Interface
- `MAX_WAIT`, default 16: maximum number of REQ cycles to wait for `mem_ack` (legal range 1..255).
- `clk`  in  1  — system clock; all logic is on the rising edge.
- `rst_n`  in  1  — reset, asynchronous and active-low.
- `start`  in  1  — a load/store instruction is present; sampled only in IDLE.
- `is_store`  in  1  — 1 for a store, 0 for a load.
- `funct3`  in  3  — RISC-V width/sign field. Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU. Stores: 000 SB, 001 SH, 010 SW.
- `addr`  in  32  — effective address (ALU `o_data`).
- `wdata`  in  32  — store data (rs2).
- `o_busy`  out  1  — stall request to the core.
- `o_done`  out  1  — one-cycle completion pulse.
- `o_status`  out  2  — valid while `o_done` is high: 00 ok, 01 misaligned, 10 illegal `funct3`, 11 timeout.
- `o_rdata`  out  32  — extended load result.
- `o_mem_req`  out  1  — bus request.
- `o_mem_we`  out  1  — bus write enable.
- `o_mem_addr`  out  32  — word-aligned address: `{addr[31:2], 2'b00}`.
- `o_mem_wdata`  out  32  — lane-replicated store data.
- `o_mem_be`  out  4  — byte enables.
- `mem_ack`  in  1  — bus acknowledge; meaningful only while `o_mem_req` is high.
- `mem_rdata`  in  32  — read word, valid in the same cycle as `mem_ack`.

## Operation
- FSM states:
  - IDLE. If `start` is high, latch `is_store`, `funct3`, `addr` and `wdata`. Then:
    - illegal `funct3` → DONE with status 10;
    - misaligned address → DONE with status 01;
    - otherwise → REQ.
  - REQ. Stay in REQ until one of:
    - `mem_ack` is high → DONE with status 00;
    - `MAX_WAIT` REQ cycles have elapsed without `mem_ack` → DONE with status 11.
  - DONE. Lasts one cycle, then → IDLE unconditionally. `start` is ignored.
- Illegal `funct3`: loads 011, 110, 111; stores 011 through 111.
- Misaligned: halfword access with `addr[0]`=1; word access with `addr[1:0]`≠0. Illegal encoding takes priority over misalignment.
- Error paths issue no bus traffic.
- `o_busy` is high in REQ only.
- The core advances its PC on the `o_done` cycle. A `start` that is still high in the DONE cycle therefore belongs to no instruction and is dropped.
- Bus outputs are registered and stay stable for the whole of REQ. Outside REQ: `o_mem_req`=0, `o_mem_we`=0, `o_mem_be`=0.
- With off = `addr[1:0]`:
  - SB/LB/LBU: be = `4'b0001 << off`.
  - SH/LH/LHU: be = `4'b0011 << off`.
  - SW/LW: be = 1111.
  - Store data: SB replicates the byte into all four lanes; SH replicates the halfword into both halves; SW passes through.
- Load extraction: shift `mem_rdata` right by 8·off, take the low byte or halfword, then sign-extend (LB/LH) or zero-extend (LBU/LHU). LW passes through.
- `o_rdata` update rule:
  - successful load: registered on the ack edge;
  - store: unchanged;
  - any error: set to 0.
- Wait counter: cleared on entry to REQ, incremented on each REQ cycle without ack. At count = `MAX_WAIT`−1 with no ack → timeout. An ack arriving in that same cycle wins, giving status 00.
- `mem_ack` seen outside REQ is ignored.

## Timing
- Reset values: state IDLE, counter 0, every output 0. Reset takes effect asynchronously at any point.
- Reset asserted during REQ drops `o_mem_req` immediately; no `o_done` is produced for the aborted access.
- Legal access, `start` in cycle 0: REQ in cycle 1.
  - Ack in cycle k (k ≥ 1) → `o_done` and `o_rdata` valid in cycle k+1; back in IDLE in cycle k+2.
  - Minimum start-to-done latency is 2 cycles.
- Error access, `start` in cycle 0: `o_done` with status 01 or 10 in cycle 1; IDLE in cycle 2.
- Timeout: `o_mem_req` is high for exactly `MAX_WAIT` cycles (cycles 1..`MAX_WAIT`); `o_done` with status 11 in cycle `MAX_WAIT`+1.
- Maximum throughput: one access every 3 cycles with zero-wait memory.

## Test plan
- LW from 0x100 with `mem_rdata`=0xDEADBEEF, ack in cycle 1:
  - required: `o_mem_req` high only in cycle 1, addr 0x100, be 1111;
  - `o_done` in cycle 2 with `o_rdata`=0xDEADBEEF, status 00.
- LB and LBU from 0x103 with `mem_rdata`=0x80FF7F01:
  - LB → `o_rdata`=0xFFFFFF80, be 1000;
  - LBU → `o_rdata`=0x00000080.
- SH to 0x202 with `wdata`=0x1234ABCD:
  - required: addr 0x200, we=1, be 1100, `o_mem_wdata`=0xABCDABCD;
  - `o_rdata` keeps its previous value.
- LW from 0x101, and SW with `funct3`=011:
  - LW → `o_done` in cycle 1, status 01, `o_mem_req` never asserted;
  - SW → status 10.
- Timeout, `MAX_WAIT`=4, ack never asserted:
  - required: req high for cycles 1–4; done in cycle 5 with status 11 and `o_rdata`=0.
  - Repeat with ack in cycle 4 → status 00.
- Reset and stray inputs:
  - `rst_n` low in cycle 2 of a wait → `o_mem_req`=0 and `o_busy`=0 immediately; no `o_done`.
  - `start` held high through DONE → exactly one access performed.
